// File: rtl/axi_packet_arbiter_pkg.sv
// axi_packet_arbiter_pkg: FSM state encoding and index-width helper shared by the arbiter files.
package axi_packet_arbiter_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational winner search, rotating from ptr (round-robin) or from 0 (fixed).
module arb_rr_pick #(
    parameter int NUM_INPUTS = 4,
    parameter int IDXW       = 2
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDXW-1:0]       ptr,
    input  logic                  mode,
    output logic [IDXW-1:0]       winner,
    output logic                  any
);

    logic [IDXW-1:0] idx;
    logic            found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = mode ? IDXW'(k) : IDXW'((int'(ptr) + k) % NUM_INPUTS);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axi_packet_arbiter.sv
// axi_packet_arbiter: packet-granular arbiter sharing one AXI4-Stream sink between NUM_INPUTS sources.
module axi_packet_arbiter
    import axi_packet_arbiter_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int NUM_INPUTS = 4,
    parameter  int PRIO_MODE  = 0,
    localparam int IDXW       = clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [WIDTH*NUM_INPUTS-1:0] i_tdata,
    input  logic [NUM_INPUTS-1:0]       i_tlast,
    input  logic [NUM_INPUTS-1:0]       i_tvalid,
    output logic [NUM_INPUTS-1:0]       i_tready,
    output logic [WIDTH-1:0]            o_tdata,
    output logic                        o_tlast,
    output logic                        o_tvalid,
    input  logic                        o_tready,
    output logic [IDXW-1:0]             grant_idx,
    output logic                        busy
);

    localparam logic FIXED = (PRIO_MODE != 0);

    state_t          state, state_n;
    logic [IDXW-1:0] rr_ptr, rr_ptr_n, grant_n, winner;
    logic            any, pkt_end;
    logic [WIDTH-1:0] data_arr [NUM_INPUTS];

    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_unpack
        assign data_arr[n] = i_tdata[n*WIDTH +: WIDTH];
    end

    arb_rr_pick #(.NUM_INPUTS(NUM_INPUTS), .IDXW(IDXW)) u_pick (
        .req    (i_tvalid),
        .ptr    (rr_ptr),
        .mode   (FIXED),
        .winner (winner),
        .any    (any)
    );

    // Mux is driven from grant_idx even in IDLE so the data path never changes source spuriously.
    assign busy     = (state == ST_GRANT);
    assign o_tdata  = data_arr[grant_idx];
    assign o_tlast  = i_tlast[grant_idx];
    assign o_tvalid = busy && i_tvalid[grant_idx];
    assign i_tready = (busy && o_tready) ? NUM_INPUTS'(1) << grant_idx : '0;
    assign pkt_end  = o_tvalid && o_tready && o_tlast;

    always_comb begin
        state_n  = state;
        grant_n  = grant_idx;
        rr_ptr_n = rr_ptr;
        if (!busy && any) begin
            state_n = ST_GRANT;
            grant_n = winner;
        end
        if (pkt_end) begin
            state_n  = ST_IDLE;
            rr_ptr_n = FIXED ? rr_ptr : (grant_idx == IDXW'(NUM_INPUTS - 1) ? '0 : grant_idx + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            grant_idx <= grant_n;
        end
    end

endmodule
